// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Scoreboarded operand fetch with a one-entry output stage.
//            Optional writeback bypass: define OPFETCH_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic        in_use_rs,
  input  logic        in_use_rt,
  input  logic        in_regwrite,

  output logic [4:0]  rf_read_reg1,
  output logic [4:0]  rf_read_reg2,
  input  logic [31:0] rf_read_data1,
  input  logic [31:0] rf_read_data2,

  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [4:0]  out_rd,
  output logic        out_regwrite,

  output logic [31:0] busy_vec
);

  logic [31:0] busy_q;
  logic        byp_rs;
  logic        byp_rt;
  logic        raw_rs;
  logic        raw_rt;
  logic        waw;
  logic        hazard;
  logic        accept;
  logic [31:0] opnd1;
  logic [31:0] opnd2;

  assign busy_vec     = busy_q;
  assign rf_read_reg1 = in_rs;
  assign rf_read_reg2 = in_rt;

`ifdef OPFETCH_WB_BYPASS_EN
  assign byp_rs = wb_valid && (wb_reg == in_rs) && (in_rs != 5'd0);
  assign byp_rt = wb_valid && (wb_reg == in_rt) && (in_rt != 5'd0);
  assign opnd1  = byp_rs ? wb_data : rf_read_data1;
  assign opnd2  = byp_rt ? wb_data : rf_read_data2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
  assign opnd1  = rf_read_data1;
  assign opnd2  = rf_read_data2;
`endif

  // Destination hazard is never bypassed: the older write must retire first.
  assign raw_rs   = in_use_rs && busy_q[in_rs] && !byp_rs;
  assign raw_rt   = in_use_rt && busy_q[in_rt] && !byp_rt;
  assign waw      = in_regwrite && busy_q[in_rd];
  assign hazard   = raw_rs || raw_rt || waw;
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Bit 0 is only ever written by reset, so register 0 never reads busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (accept && in_regwrite && (in_rd == 5'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (wb_valid && (wb_reg == 5'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data1    <= '0;
      out_data2    <= '0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_data1    <= opnd1;
      out_data2    <= opnd2;
      out_rd       <= in_rd;
      out_regwrite <= in_regwrite;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed + randomized bench for operand_fetch with a reference
//            model; honours OPFETCH_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_use_rs, in_use_rt, in_regwrite;
  logic [4:0]  rf_read_reg1, rf_read_reg2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data1, out_data2;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic [31:0] busy_vec;

  logic [31:0] rf [32];
  assign rf_read_data1 = rf[rf_read_reg1];
  assign rf_read_data2 = rf[rf_read_reg2];

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_rs(in_use_rs), .in_use_rt(in_use_rt), .in_regwrite(in_regwrite),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data1(out_data1), .out_data2(out_data2),
    .out_rd(out_rd), .out_regwrite(out_regwrite),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending-write set, output slot and register file contents.
  bit          mb [32];
  bit          m_ov;
  logic [31:0] m_d1, m_d2;
  logic [4:0]  m_rd;
  bit          m_rw;
  bit          last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i] = mb[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mb[i] = 1'b0;
    m_ov = 1'b0; m_d1 = '0; m_d2 = '0; m_rd = '0; m_rw = 1'b0;
  endtask

  task automatic check_outputs();
    chk("busy_vec", busy_vec, model_busy());
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      chk("out_data1", out_data1, m_d1);
      chk("out_data2", out_data2, m_d2);
      chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
      chk("out_regwrite", {31'd0, out_regwrite}, {31'd0, m_rw});
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    bit b_rs, b_rt, hz, e_ready, acc;
    logic [31:0] n1, n2;
    #1;
`ifdef OPFETCH_WB_BYPASS_EN
    b_rs = wb_valid && (wb_reg == in_rs) && (in_rs != 0);
    b_rt = wb_valid && (wb_reg == in_rt) && (in_rt != 0);
`else
    b_rs = 1'b0;
    b_rt = 1'b0;
`endif
    hz = (in_use_rs && mb[in_rs] && !b_rs) || (in_use_rt && mb[in_rt] && !b_rt)
         || (in_regwrite && mb[in_rd]);
    e_ready = (!m_ov || out_ready) && !hz;
    chk("in_ready", {31'd0, in_ready}, {31'd0, e_ready});
    chk("rf_addrs", {22'd0, rf_read_reg1, rf_read_reg2}, {22'd0, in_rs, in_rt});
    last_ready = in_ready;
    acc = in_valid && e_ready;
    n1  = b_rs ? wb_data : rf[in_rs];
    n2  = b_rt ? wb_data : rf[in_rt];
    @(posedge clk);
    #1;
    if (acc) begin
      m_ov = 1'b1; m_d1 = n1; m_d2 = n2; m_rd = in_rd; m_rw = in_regwrite;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (wb_valid && wb_reg != 0) begin
      mb[wb_reg] = 1'b0;
      rf[wb_reg] = wb_data;
    end
    if (acc && in_regwrite && in_rd != 0) mb[in_rd] = 1'b1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic issue(input bit v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input bit urs, input bit urt, input bit rw);
    in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd;
    in_use_rs = urs; in_use_rt = urt; in_regwrite = rw;
  endtask

  task automatic wb(input bit v, input logic [4:0] r, input logic [31:0] d);
    wb_valid = v; wb_reg = r; wb_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i);
    reset = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy_vec, 32'd0);
    chk("reset_outs", {out_valid, out_regwrite, out_rd}, 7'd0);
    chk("reset_data", out_data1 | out_data2, 32'd0);
    reset = 1'b0;

    // Basic issue with destination tracking.
    issue(1, 5, 7, 9, 1, 1, 1);
    step();
    chk("r24_d1", out_data1, 32'd5);
    chk("r24_d2", out_data2, 32'd7);
    chk("r24_rd", {27'd0, out_rd}, 32'd9);
    chk("r24_busy", busy_vec, 32'h0000_0200);

    // RAW on r9 until its writeback arrives.
    issue(1, 9, 0, 0, 1, 0, 0);
    step();
    chk("r25_stall1", {31'd0, last_ready}, 32'd0);
    step();
    chk("r25_stall2", {31'd0, last_ready}, 32'd0);
    wb(1, 9, 32'hDEAD_BEEF);
    step();
`ifdef OPFETCH_WB_BYPASS_EN
    chk("r25_byp_acc", {31'd0, last_ready}, 32'd1);
    chk("r25_byp_d1", out_data1, 32'hDEAD_BEEF);
    wb(0, 0, 0);
`else
    chk("r25_wb_stall", {31'd0, last_ready}, 32'd0);
    wb(0, 0, 0);
    step();
    chk("r25_rf_acc", {31'd0, last_ready}, 32'd1);
    chk("r25_rf_d1", out_data1, 32'hDEAD_BEEF);
`endif

    // Backpressure: held output, new instruction waits.
    out_ready = 1'b0;
    issue(1, 1, 2, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("r26_hold_rdy", {31'd0, last_ready}, 32'd0);
      chk("r26_hold_d1", out_data1, 32'hDEAD_BEEF);
    end
    out_ready = 1'b1;
    step();
    chk("r26_load_d1", out_data1, 32'd1);
    chk("r26_load_d2", out_data2, 32'd2);

    // WAW is not bypassed even with a same-cycle writeback.
    issue(1, 0, 0, 4, 0, 0, 1);
    step();
    chk("r27_busy4", busy_vec, 32'h0000_0010);
    wb(1, 4, 32'h4444_4444);
    step();
    chk("r27_waw", {31'd0, last_ready}, 32'd0);
    wb(0, 0, 0);
    step();
    chk("r27_acc", {31'd0, last_ready}, 32'd1);
    chk("r27_busy_after", busy_vec, 32'h0000_0010);
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(1, 4, 32'h4444_0004);
    step();

    // Register 0 is never tracked.
    issue(1, 0, 0, 0, 0, 0, 1);
    step();
    chk("r28_busy_rd0", busy_vec, 32'd0);
    issue(1, 0, 0, 0, 1, 0, 0);
    wb(0, 0, 0);
    step();
    chk("r28_nostall", {31'd0, last_ready}, 32'd1);
    issue(0, 0, 0, 0, 0, 0, 0);
    wb(1, 0, 32'h1234_5678);
    step();
    chk("r28_wb0", busy_vec, 32'd0);
    wb(0, 0, 0);

    // Asynchronous reset in the middle of activity.
    issue(1, 0, 0, 3, 0, 0, 1);
    step();
    issue(1, 0, 0, 8, 0, 0, 1);
    step();
    chk("r29_pre_busy", busy_vec, 32'h0000_0108);
    issue(0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("r29_busy_now", busy_vec, 32'd0);
    chk("r29_ov_now", {31'd0, out_valid}, 32'd0);
    chk("r29_data_now", out_data1 | out_data2, 32'd0);
    chk("r29_rd_now", {26'd0, out_rd, out_regwrite}, 32'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    issue(1, 3, 0, 0, 1, 0, 0);
    step();
    chk("r29_after_acc", {31'd0, last_ready}, 32'd1);

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      wb(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: in_valid  in  1  decoded instruction present; in_ready  out  1  instruction accepted this cycle.
REQ-004 SHALL have ports: in_rs, in_rt, in_rd  in  5 each  source/destination register numbers.
REQ-005 SHALL have ports: in_use_rs, in_use_rt, in_regwrite  in  1 each  operand-used / destination-written flags.
REQ-006 SHALL have ports: rf_read_reg1, rf_read_reg2  out  5 each  register-file read addresses, driven combinationally from in_rs, in_rt.
REQ-007 SHALL have ports: rf_read_data1, rf_read_data2  in  32 each  register-file read data, combinational and same-cycle.
REQ-008 SHALL have ports: wb_valid  in  1, wb_reg  in  5, wb_data  in  32  writeback completing to the register file at this rising edge.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data1, out_data2  out  32; out_rd  out  5; out_regwrite  out  1  one-entry output stage.
REQ-010 SHALL have ports: busy_vec  out  32  scoreboard contents, for observation.

Function
REQ-011 SHALL keep a 32-bit scoreboard busy[31:0]; busy[0] SHALL be constantly 0.
REQ-012 hazard SHALL equal (in_use_rs & busy[in_rs] & !byp_rs) | (in_use_rt & busy[in_rt] & !byp_rt) | (in_regwrite & busy[in_rd]); byp_x is defined in REQ-021.
REQ-013 in_ready SHALL equal (!out_valid | out_ready) & !hazard; in_ready is independent of in_valid.
REQ-014 accept SHALL equal in_valid & in_ready; on accept the output stage SHALL load operands, in_rd and in_regwrite, and SHALL set out_valid, giving 1-cycle latency.
REQ-015 Output stage SHALL hold all values stable while out_valid & !out_ready.
REQ-016 When out_ready is high and there is no accept, out_valid SHALL clear at the next edge.
REQ-017 On accept with in_regwrite & in_rd!=0, busy[in_rd] SHALL set at the edge.
REQ-018 When wb_valid & wb_reg!=0, busy[wb_reg] SHALL clear at the edge. If the same register is set by REQ-017 in the same cycle, the set SHALL win.
REQ-019 wb_valid to a non-busy register, or to register 0, SHALL have no scoreboard effect and no error.
REQ-020 Operands SHALL be registered 32-bit values without modification. An unused operand (in_use_x=0) SHALL still load the register-file value.

Reset
REQ-022 While reset is high: busy_vec=0, out_valid=0, out_data1=0, out_data2=0, out_rd=0, out_regwrite=0.
REQ-023 Reset mid-operation SHALL discard the held output and all pending scoreboard entries. No writeback after reset SHALL be required to unblock.

Configuration
REQ-021 Macro OPFETCH_WB_BYPASS_EN controls writeback bypass.
- Defined: byp_x = wb_valid & (wb_reg==in_x) & in_x!=0. When byp_x is true, the operand SHALL be taken from wb_data instead of rf_read_data, and no stall occurs.
- Undefined: byp_x SHALL be 0. A RAW operand stalls until the busy bit clears, then is read from the register file the following cycle.
- WAW stall (REQ-012) SHALL never be bypassed in either configuration.

Verification
REQ-024 Reset, RF preloaded reg i = i; issue rs=5, rt=7, use both, regwrite rd=9 -> next cycle out_data1=5, out_data2=7, out_rd=9, busy_vec=0x00000200.
REQ-025 busy[9] set; issue rs=9 with out_ready=1 -> in_ready=0 each cycle. wb_valid, wb_reg=9, wb_data=0xDEADBEEF:
- Bypass build: accepted same cycle, out_data1=0xDEADBEEF.
- Non-bypass build: accepted next cycle, out_data1=0xDEADBEEF read from the register file.
REQ-026 out_ready=0 with out_valid=1 and new in_valid -> in_ready=0. Outputs stay unchanged for 3 cycles, then out_ready=1 -> next instruction loads the following cycle.
REQ-027 Same cycle: accept with regwrite rd=4, and wb_valid wb_reg=4 with busy[4]=1 -> in_ready=0 because of WAW. Next cycle accept -> busy[4]=1 afterwards.
REQ-028 Issue regwrite rd=0, then rs=0 -> busy_vec stays 0 and no stall. wb_valid wb_reg=0 -> no change.
REQ-029 busy[3], busy[8] set and out_valid=1; assert reset between edges -> busy_vec=0 and out_valid=0 immediately. After release, issue rs=3 -> accepted without stall.
